riscv_irq_ctrl: RTL

RISCV_IRQ_CTRL -- requirements
Module: riscv_irq_ctrl

---
 rtl/riscv_irq_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/riscv_irq_ctrl.sv
// riscv_irq_ctrl: machine-level timer / software / external interrupt
// controller for a small RISC-V core.
//
// Holds MTIME (64-bit, prescaled by TICK_DIV), MTIMECMP and MSIP behind a
// tiny MMIO port, synchronizes the external interrupt line, and raises a
// registered interrupt request with a cause code towards the CSR block.
//
// Ports
//   clk          core clock, all state changes on its rising edge
//   rst_n        synchronous reset, active-HIGH despite its name
//   req_valid    MMIO request strobe (always accepted, no stall)
//   req_wen      1 = write, 0 = read
//   req_addr     byte address, [4:2] selects the register
//   req_wdata    write data
//   resp_valid   one-cycle response strobe, one cycle after the request
//   resp_rdata   read data (0 for writes), valid with resp_valid
//   ext_irq      asynchronous level external interrupt
//   mie_glb      mstatus.MIE
//   mie_mask     {MEIE, MTIE, MSIE}
//   trap_taken   trap acknowledge from the CSR block
//   intr_req     registered interrupt request
//   intr_cause   cause code, valid while intr_req = 1
//   mip          pending view: bit11 MEIP, bit7 MTIP, bit3 MSIP
//
// Register map: 0x00 MSIP (bit0), 0x04/0x08 MTIMECMP lo/hi,
//               0x0C/0x10 MTIME lo/hi; other offsets read 0, ignore writes.
module riscv_irq_ctrl #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_wen,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  input  logic        ext_irq,
  input  logic        mie_glb,
  input  logic [2:0]  mie_mask,
  input  logic        trap_taken,
  output logic        intr_req,
  output logic [3:0]  intr_cause,
  output logic [31:0] mip
);

  localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  localparam logic [2:0] SEL_MSIP    = 3'd0;
  localparam logic [2:0] SEL_CMP_LO  = 3'd1;
  localparam logic [2:0] SEL_CMP_HI  = 3'd2;
  localparam logic [2:0] SEL_TIME_LO = 3'd3;
  localparam logic [2:0] SEL_TIME_HI = 3'd4;

  localparam logic [3:0] CAUSE_MEI = 4'd11;
  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [3:0]    cause_next;

  logic [63:0]   mtime;
  logic [63:0]   mtimecmp;
  logic          msip;
  logic          mtip;
  logic [1:0]    ext_sync;
  logic [PW-1:0] presc;

  logic          wr;
  logic [2:0]    sel;
  logic          tick;
  logic [31:0]   rdata;
  logic [2:0]    pend;
  logic          cand;
  logic          addr_unused;

  // Byte lanes inside a word are not decoded.
  assign addr_unused = ^req_addr[1:0];

  assign sel  = req_addr[4:2];
  assign wr   = req_valid & req_wen;
  assign tick = (presc == PRESC_LAST);

  // Pending sources aligned with mie_mask = {MEIE, MTIE, MSIE}.
  assign pend = {ext_sync[1], mtip, msip} & mie_mask;
  assign cand = mie_glb & (|pend);

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_MSIP:    rdata = {31'd0, msip};
      SEL_CMP_LO:  rdata = mtimecmp[31:0];
      SEL_CMP_HI:  rdata = mtimecmp[63:32];
      SEL_TIME_LO: rdata = mtime[31:0];
      SEL_TIME_HI: rdata = mtime[63:32];
      default:     rdata = '0;
    endcase
  end

  always_comb begin
    mip     = '0;
    mip[11] = ext_sync[1];
    mip[7]  = mtip;
    mip[3]  = msip;
  end

  // MMIO, timer and pending-source state.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      mtime      <= '0;
      mtimecmp   <= '1;
      msip       <= 1'b0;
      mtip       <= 1'b0;
      ext_sync   <= '0;
      presc      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= req_valid;
      resp_rdata <= (req_valid && !req_wen) ? rdata : '0;

      presc    <= tick ? '0 : presc + 1'b1;
      ext_sync <= {ext_sync[0], ext_irq};
      mtip     <= (mtime >= mtimecmp);

      if (wr && sel == SEL_MSIP)   msip            <= req_wdata[0];
      if (wr && sel == SEL_CMP_LO) mtimecmp[31:0]  <= req_wdata;
      if (wr && sel == SEL_CMP_HI) mtimecmp[63:32] <= req_wdata;

      // A software write to either half suppresses the whole increment for
      // that cycle, so the untouched half never sees a carry.
      if (wr && sel == SEL_TIME_LO) begin
        mtime[31:0] <= req_wdata;
      end else if (wr && sel == SEL_TIME_HI) begin
        mtime[63:32] <= req_wdata;
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end
    end
  end

  // Request FSM state register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= IDLE;
      intr_req   <= 1'b0;
      intr_cause <= '0;
    end else begin
      state      <= state_next;
      intr_req   <= (state_next == REQ);
      intr_cause <= cause_next;
    end
  end

  // Cause is captured only on entry to REQ and then frozen, so a later
  // higher-priority source cannot change it under the CSR block.
  always_comb begin
    state_next = state;
    cause_next = intr_cause;
    case (state)
      IDLE: begin
        if (cand) begin
          state_next = REQ;
          if (pend[2])      cause_next = CAUSE_MEI;
          else if (pend[0]) cause_next = CAUSE_MSI;
          else              cause_next = CAUSE_MTI;
        end
      end
      REQ: begin
        if (trap_taken)  state_next = ACK;
        else if (!cand)  state_next = IDLE;
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule
